// File: rtl/multu_hilo.sv
// -----------------------------------------------------------------------------
// multu_hilo
//
// Sequential unsigned multiplier with HI/LO result registers. It answers the
// ALU command stream: MULTU (funct 25) launches a shift-add multiply of the
// two operands, one multiplier bit per clock. The 2*WIDTH-bit product lands
// in HI/LO, which are read back with MFHI (funct 16) and MFLO (funct 18).
//
// Ports
//   clk      in   1       rising-edge clock
//   reset    in   1       synchronous active-high reset
//   dataA    in   WIDTH   multiplicand, captured at start
//   dataB    in   WIDTH   multiplier, captured at start
//   signal   in   6       funct code (25 MULTU, 16 MFHI, 18 MFLO)
//   dataOut  out  WIDTH   HI on MFHI, LO on MFLO, zero otherwise
//   busy     out  1       a multiply is in RUN or DONE
//   done     out  1       one-cycle pulse after HI/LO are written
//
// Timing: a start sampled at edge N iterates on edges N+1..N+32 and writes
// HI/LO at edge N+33; done is high for the cycle after N+33.
// -----------------------------------------------------------------------------
module multu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       signal,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done
);

  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam int         CW          = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_mulPrev;
  logic               r_done;

  logic               w_isMult;
  logic               w_start;
  logic               w_lastIter;

  // The start is edge-detected on the MULTU code so that a command held for
  // many cycles launches exactly one multiply. r_mulPrev keeps tracking the
  // code while busy, so a MULTU that rose mid-operation never fires later.
  assign w_isMult   = (signal == FUNCT_MULTU);
  assign w_start    = (r_state == IDLE) && w_isMult && !r_mulPrev;
  assign w_lastIter = (r_count == LAST_ITER);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: IDLE -> RUN on start, RUN for WIDTH iterations,
  // then a single DONE cycle that commits the result.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_start) w_nextState = RUN;
      RUN:  if (w_lastIter) w_nextState = DONE;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath. The product accumulator is 2*WIDTH wide and the multiplicand
  // is pre-extended, so the running sum can never overflow. HI/LO are only
  // touched in DONE, so an aborting reset leaves nothing half-written
  // except the clear to zero that reset itself performs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand   <= '0;
      r_prod    <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mulPrev <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_mulPrev <= w_isMult;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, dataA};
            r_mplier <= dataB;
            r_prod   <= '0;
            r_count  <= '0;
          end
        end
        RUN: begin
          if (r_mplier[0]) begin
            r_prod <= r_prod + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
        end
        DONE: begin
          r_hi   <= r_prod[2*WIDTH-1:WIDTH];
          r_lo   <= r_prod[WIDTH-1:0];
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read port is purely combinational so MFHI/MFLO return data in the same
  // cycle the code is presented; reads while busy see the previous result.
  always_comb begin
    dataOut = '0;
    case (signal)
      FUNCT_MFHI: dataOut = r_hi;
      FUNCT_MFLO: dataOut = r_lo;
      default:    dataOut = '0;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;

endmodule

// File: tb/tb_multu_hilo.sv
// -----------------------------------------------------------------------------
// tb_multu_hilo
//
// Directed self-checking bench for multu_hilo. Each scenario task drives its
// own stimulus and compares against hand-computed products.
// -----------------------------------------------------------------------------
module tb_multu_hilo;

  logic        clk;
  logic        reset;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  int doneCount;

  multu_hilo #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .dataA   (dataA),
    .dataB   (dataB),
    .signal  (signal),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses on the falling edge, mid-cycle.
  initial doneCount = 0;
  always @(negedge clk) begin
    if (done === 1'b1) doneCount = doneCount + 1;
  end

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a multiply, hold MULTU 35 cycles, then release the code.
  task automatic runMultu(input logic [31:0] a, input logic [31:0] b);
    dataA  = a;
    dataB  = b;
    signal = 6'd25;
    for (int i = 0; i < 35; i++) tick();
    signal = 6'd0;
    tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    signal = 6'd0;
    dataA  = '0;
    dataB  = '0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy got=%0b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_done got=%0b exp=0", done);
    end
    signal = 6'd16;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mfhi got=%h exp=0", dataOut);
    end
    signal = 6'd18;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mflo got=%h exp=0", dataOut);
    end
    // Reset together with a start condition: reset wins.
    signal = 6'd25;
    dataA  = 32'd3;
    dataB  = 32'd5;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_vs_start got=%0b exp=0", busy);
    end
    signal = 6'd0;
    reset  = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int doneTick;
    int startDone;
    startDone = doneCount;
    doneTick  = -1;
    dataA  = 32'd3;
    dataB  = 32'd5;
    signal = 6'd25;
    tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_busy_after_start got=%0b exp=1", busy);
    end
    for (int t = 2; t <= 35; t++) begin
      tick();
      if (done === 1'b1 && doneTick < 0) doneTick = t;
    end
    checks++;
    if (doneTick != 34) begin
      failures++;
      $display("[TB] FAIL basic_done_cycle got=%0d exp=34", doneTick);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_busy_end got=%0b exp=0", busy);
    end
    signal = 6'd0;
    tick();
    signal = 6'd16;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL basic_mfhi got=%h exp=00000000", dataOut);
    end
    signal = 6'd18;
    #1;
    checks++;
    if (dataOut !== 32'd15) begin
      failures++;
      $display("[TB] FAIL basic_mflo got=%h exp=0000000f", dataOut);
    end
    checks++;
    if (doneCount - startDone != 1) begin
      failures++;
      $display("[TB] FAIL basic_done_count got=%0d exp=1", doneCount - startDone);
    end
    signal = 6'd0;
    tick();
  endtask

  task automatic test_max();
    runMultu(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    signal = 6'd16;
    #1;
    checks++;
    if (dataOut !== 32'hFFFF_FFFE) begin
      failures++;
      $display("[TB] FAIL max_mfhi got=%h exp=fffffffe", dataOut);
    end
    signal = 6'd18;
    #1;
    checks++;
    if (dataOut !== 32'h0000_0001) begin
      failures++;
      $display("[TB] FAIL max_mflo got=%h exp=00000001", dataOut);
    end
    signal = 6'd0;
    tick();
  endtask

  task automatic test_held();
    int startDone;
    startDone = doneCount;
    dataA  = 32'h8000_0000;
    dataB  = 32'd4;
    signal = 6'd25;
    for (int i = 0; i < 80; i++) tick();
    signal = 6'd0;
    tick();
    checks++;
    if (doneCount - startDone != 1) begin
      failures++;
      $display("[TB] FAIL held_done_count got=%0d exp=1", doneCount - startDone);
    end
    signal = 6'd16;
    #1;
    checks++;
    if (dataOut !== 32'd2) begin
      failures++;
      $display("[TB] FAIL held_mfhi got=%h exp=00000002", dataOut);
    end
    signal = 6'd18;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL held_mflo got=%h exp=00000000", dataOut);
    end
    signal = 6'd0;
    tick();
  endtask

  task automatic test_busy_ignore();
    int startDone;
    startDone = doneCount;
    dataA  = 32'd7;
    dataB  = 32'd6;
    signal = 6'd25;
    for (int i = 0; i < 10; i++) tick();
    signal = 6'd0;
    tick();
    dataA  = 32'd9;
    signal = 6'd25;
    tick();
    signal = 6'd0;
    for (int i = 0; i < 80; i++) tick();
    checks++;
    if (doneCount - startDone != 1) begin
      failures++;
      $display("[TB] FAIL busy_ignore_done_count got=%0d exp=1", doneCount - startDone);
    end
    signal = 6'd18;
    #1;
    checks++;
    if (dataOut !== 32'd42) begin
      failures++;
      $display("[TB] FAIL busy_ignore_mflo got=%h exp=0000002a", dataOut);
    end
    signal = 6'd0;
    tick();
  endtask

  task automatic test_stale_and_codes();
    // LO = 42, HI = 0 from the previous scenario.
    dataA  = 32'd100;
    dataB  = 32'd3;
    signal = 6'd25;
    for (int i = 0; i < 5; i++) tick();
    signal = 6'd18;
    #1;
    checks++;
    if (busy !== 1'b1 || dataOut !== 32'd42) begin
      failures++;
      $display("[TB] FAIL stale_mflo got=%h busy=%0b exp=0000002a busy=1", dataOut, busy);
    end
    signal = 6'd32;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL code32_out got=%h exp=00000000", dataOut);
    end
    signal = 6'd42;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL code42_out got=%h exp=00000000", dataOut);
    end
    for (int i = 0; i < 40; i++) tick();
    signal = 6'd18;
    #1;
    checks++;
    if (dataOut !== 32'd300) begin
      failures++;
      $display("[TB] FAIL stale_new_mflo got=%h exp=0000012c", dataOut);
    end
    signal = 6'd16;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL stale_new_mfhi got=%h exp=00000000", dataOut);
    end
    signal = 6'd0;
    tick();
  endtask

  task automatic test_reset_mid();
    int startDone;
    runMultu(32'd3, 32'd5);
    startDone = doneCount;
    dataA  = 32'd100;
    dataB  = 32'd100;
    signal = 6'd25;
    for (int i = 0; i < 20; i++) tick();
    reset  = 1'b1;
    signal = 6'd0;
    tick();
    reset  = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset_busy got=%0b exp=0", busy);
    end
    signal = 6'd18;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL midreset_lo got=%h exp=00000000", dataOut);
    end
    signal = 6'd16;
    #1;
    checks++;
    if (dataOut !== 32'd0) begin
      failures++;
      $display("[TB] FAIL midreset_hi got=%h exp=00000000", dataOut);
    end
    signal = 6'd0;
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if (doneCount - startDone != 0) begin
      failures++;
      $display("[TB] FAIL midreset_done_count got=%0d exp=0", doneCount - startDone);
    end
    runMultu(32'd100, 32'd100);
    signal = 6'd18;
    #1;
    checks++;
    if (dataOut !== 32'd10000) begin
      failures++;
      $display("[TB] FAIL rerun_mflo got=%h exp=00002710", dataOut);
    end
    checks++;
    if (doneCount - startDone != 1) begin
      failures++;
      $display("[TB] FAIL rerun_done_count got=%0d exp=1", doneCount - startDone);
    end
    signal = 6'd0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    signal   = 6'd0;
    dataA    = '0;
    dataB    = '0;
    test_reset();
    test_basic();
    test_max();
    test_held();
    test_busy_ignore();
    test_stale_and_codes();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
